// File: rtl/column_frame_sequencer.sv
// column_frame_sequencer
//   Frame-level controller for the column rectangle drawer. Walks the screen
//   one column at a time, asks the ray unit for a wall height, then issues up
//   to three vertical rectangle draws (ceiling, wall, floor) to the drawer.
//
// Ports
//   clock, resetn          system clock, asynchronous active-low reset
//   frame_start            pulse: begin a frame (ignored unless idle)
//   busy, frame_done       frame in progress / one-cycle completion pulse
//   col_req, col_index     height request to the ray unit and its column
//   height_valid,          ray unit response strobe with height and
//   height_in,             wall colour for col_index
//   wall_color_in
//   start_plot, end_plot   drawer handshake (pulse out, completion pulse in)
//   X_pos, Y_pos,          segment geometry and colour, stable from
//   rect_size, color       start_plot until end_plot
module column_frame_sequencer #(
  parameter int         NUM_COLS    = 160,
  parameter int         SCREEN_H    = 120,
  parameter logic [2:0] CEIL_COLOR  = 3'b001,
  parameter logic [2:0] FLOOR_COLOR = 3'b010
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_start,
  output logic       busy,
  output logic       frame_done,
  output logic       col_req,
  output logic [7:0] col_index,
  input  logic       height_valid,
  input  logic [6:0] height_in,
  input  logic [2:0] wall_color_in,
  output logic       start_plot,
  input  logic       end_plot,
  output logic [7:0] X_pos,
  output logic [6:0] Y_pos,
  output logic [6:0] rect_size,
  output logic [2:0] color
);

  localparam logic [6:0] SH       = 7'(SCREEN_H);
  localparam logic [7:0] LAST_COL = 8'(NUM_COLS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_CEIL_GO, S_CEIL_WAIT, S_WALL_GO, S_WALL_WAIT,
    S_FLOOR_GO, S_FLOOR_WAIT, S_GAP, S_NEXT, S_DONE
  } state_t;

  state_t     state_q;
  logic       busy_q, frame_done_q, col_req_q, start_plot_q;
  logic [7:0] col_q;
  logic [6:0] y_q, size_q, h_q, top_q;
  logic [2:0] color_q, wall_color_q;
  logic [2:0] pend_q;   // {floor, wall, ceiling} segments still to draw

  logic [6:0] h_d, top_d, top_s, h_s, floor_y_s, floor_sz_s;
  logic [2:0] wcol_s, pend_d, mask;
  logic       use_new, go_any;
  state_t     go_state;
  logic [6:0] go_y, go_sz;
  logic [2:0] go_color, go_bit;

  // Segment selection is shared by the handshake cycle (geometry taken
  // straight from the incoming height) and GAP (geometry from registers),
  // so the first GO can follow the handshake with no extra cycle.
  always_comb begin
    h_d        = (height_in > SH) ? SH : height_in;
    top_d      = (SH - h_d) >> 1;
    use_new    = (state_q == S_REQ);
    top_s      = use_new ? top_d : top_q;
    h_s        = use_new ? h_d : h_q;
    wcol_s     = use_new ? wall_color_in : wall_color_q;
    floor_y_s  = top_s + h_s;
    floor_sz_s = SH - floor_y_s;   // odd remainder lands here
    pend_d     = {(SH - top_d - h_d) != '0, h_d != '0, top_d != '0};
    mask       = use_new ? pend_d : pend_q;
    go_any     = 1'b1;
    go_state   = S_CEIL_GO;
    go_y       = '0;
    go_sz      = top_s;
    go_color   = CEIL_COLOR;
    go_bit     = 3'b001;
    if (mask[0]) begin
      go_state = S_CEIL_GO;
    end else if (mask[1]) begin
      go_state = S_WALL_GO;
      go_y     = top_s;
      go_sz    = h_s;
      go_color = wcol_s;
      go_bit   = 3'b010;
    end else if (mask[2]) begin
      go_state = S_FLOOR_GO;
      go_y     = floor_y_s;
      go_sz    = floor_sz_s;
      go_color = FLOOR_COLOR;
      go_bit   = 3'b100;
    end else begin
      go_any   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      col_req_q    <= 1'b0;
      start_plot_q <= 1'b0;
      col_q        <= '0;
      y_q          <= '0;
      size_q       <= '0;
      color_q      <= '0;
      h_q          <= '0;
      top_q        <= '0;
      wall_color_q <= '0;
      pend_q       <= '0;
    end else begin
      start_plot_q <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (frame_start) begin
          col_q     <= '0;
          busy_q    <= 1'b1;
          col_req_q <= 1'b1;
          state_q   <= S_REQ;
        end
        S_REQ, S_GAP: begin
          if (state_q == S_REQ) begin
            if (col_req_q && height_valid) begin
              col_req_q    <= 1'b0;
              h_q          <= h_d;
              top_q        <= top_d;
              wall_color_q <= wall_color_in;
            end
          end
          if (state_q == S_GAP || (col_req_q && height_valid)) begin
            if (go_any) begin
              state_q      <= go_state;
              start_plot_q <= 1'b1;
              y_q          <= go_y;
              size_q       <= go_sz;
              color_q      <= go_color;
              pend_q       <= mask & ~go_bit;
            end else begin
              state_q <= S_NEXT;
            end
          end
        end
        S_CEIL_GO:    state_q <= S_CEIL_WAIT;
        S_WALL_GO:    state_q <= S_WALL_WAIT;
        S_FLOOR_GO:   state_q <= S_FLOOR_WAIT;
        S_CEIL_WAIT, S_WALL_WAIT, S_FLOOR_WAIT:
          if (end_plot) state_q <= S_GAP;
        S_NEXT: begin
          if (col_q == LAST_COL) begin
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            col_q     <= col_q + 8'd1;
            col_req_q <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign col_req    = col_req_q;
  assign col_index  = col_q;
  assign start_plot = start_plot_q;
  assign X_pos      = col_q;
  assign Y_pos      = y_q;
  assign rect_size  = size_q;
  assign color      = color_q;

endmodule
